// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter sizing for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} piso_state_t;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, registered MSB/LSB-first bit stream out.
// Define PISO_PARITY_EN to append one even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_dout,
    output logic             o_dout_n,
    output logic             o_bit_vld,
    output logic             o_sof
);

    localparam int CW = cnt_width(WIDTH);

    piso_state_t      state_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             dout_q;
    logic             vld_q;
    logic             sof_q;
    logic [WIDTH-1:0] word_d;
    logic             last_bit;
    logic             accept;

    // The shifter always emits from the MSB, so LSB-first words are reversed on load.
    always_comb begin
        word_d = i_data;
        if (LSB_FIRST)
            for (int k = 0; k < WIDTH; k++)
                word_d[k] = i_data[WIDTH-1-k];
    end

`ifdef PISO_PARITY_EN
    logic par_q;

    assign last_bit = (state_q == PAR);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            par_q <= 1'b0;
        else if (accept)
            par_q <= ^i_data;
    end
`else
    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
`endif

    assign o_ready   = i_rst_n & ((state_q == IDLE) | last_bit);
    assign accept    = i_valid & o_ready;
    assign o_dout    = dout_q;
    assign o_dout_n  = ~dout_q;
    assign o_bit_vld = vld_q;
    assign o_sof     = sof_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
        end else if (accept) begin
            state_q <= SHIFT;
            dout_q  <= word_d[WIDTH-1];
            sr_q    <= word_d << 1;
            cnt_q   <= CW'(WIDTH - 1);
            vld_q   <= 1'b1;
            sof_q   <= 1'b1;
        end else if (state_q == SHIFT && cnt_q != '0) begin
            dout_q  <= sr_q[WIDTH-1];
            sr_q    <= sr_q << 1;
            cnt_q   <= cnt_q - 1'b1;
            sof_q   <= 1'b0;
`ifdef PISO_PARITY_EN
        end else if (state_q == SHIFT) begin
            state_q <= PAR;
            dout_q  <= par_q;
            sof_q   <= 1'b0;
`endif
        end else begin
            state_q <= IDLE;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed scenarios plus random traffic against a frame-queue reference model.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_data = '0;
    logic         o_ready, o_dout, o_dout_n, o_bit_vld, o_sof;
    logic         l_ready, l_dout, l_dout_n, l_bit_vld, l_sof;

    int checks = 0;
    int errors = 0;
    bit sb_en = 1'b0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_dout(o_dout), .o_dout_n(o_dout_n),
        .o_bit_vld(o_bit_vld), .o_sof(o_sof)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_ready(l_ready), .o_dout(l_dout), .o_dout_n(l_dout_n),
        .o_bit_vld(l_bit_vld), .o_sof(l_sof)
    );

    // Reference model: q[0] is the {sof,bit} currently on the line, later entries are still to come.
    logic [1:0] q[$];
    logic [1:0] ql[$];
    logic       acc;

    always @(posedge clk) begin
        if (!i_rst_n) begin
            q.delete();
            ql.delete();
        end else begin
            acc = i_valid && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc)
                for (int i = 0; i < FL; i++) begin
                    q.push_back({i == 0, (i == W) ? ^i_data : i_data[W-1-i]});
                    ql.push_back({i == 0, (i == W) ? ^i_data : i_data[i]});
                end
        end
    end

    always @(negedge clk) begin
        if (sb_en) begin
            logic [1:0] e, el;
            logic       er;
            e  = (q.size() > 0) ? q[0] : 2'b00;
            el = (ql.size() > 0) ? ql[0] : 2'b00;
            er = i_rst_n && (q.size() <= 1);
            checks++;
            if (o_dout !== e[0]) begin errors++; $display("FAIL sb_dout t=%0t got %b exp %b", $time, o_dout, e[0]); end
            checks++;
            if (o_dout_n !== ~e[0]) begin errors++; $display("FAIL sb_dout_n t=%0t got %b exp %b", $time, o_dout_n, ~e[0]); end
            checks++;
            if (o_bit_vld !== (q.size() > 0)) begin errors++; $display("FAIL sb_vld t=%0t got %b exp %b", $time, o_bit_vld, q.size() > 0); end
            checks++;
            if (o_sof !== e[1]) begin errors++; $display("FAIL sb_sof t=%0t got %b exp %b", $time, o_sof, e[1]); end
            checks++;
            if (o_ready !== er) begin errors++; $display("FAIL sb_ready t=%0t got %b exp %b", $time, o_ready, er); end
            checks++;
            if ({l_sof, l_dout} !== el) begin errors++; $display("FAIL sb_lsb t=%0t got %b exp %b", $time, {l_sof, l_dout}, el); end
            checks++;
            if ({l_ready, l_bit_vld, l_dout_n} !== {er, ql.size() > 0, ~el[0]}) begin
                errors++;
                $display("FAIL sb_lsb_ctl t=%0t got %b exp %b", $time, {l_ready, l_bit_vld, l_dout_n}, {er, ql.size() > 0, ~el[0]});
            end
        end
    end

    task automatic tick(input logic v, input logic [W-1:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_rst_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) tick(1'b1, 8'hAA, 1'b0);
        sb_en = 1'b1;
        checks++;
        if ({o_ready, o_dout, o_dout_n, o_bit_vld, o_sof} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00100", {o_ready, o_dout, o_dout_n, o_bit_vld, o_sof});
        end
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", o_ready); end
    endtask

    task automatic test_single_word;
        logic [7:0] pat;
        pat = 8'hA5;
        tick(1'b1, pat, 1'b1);
        for (int i = 0; i < W; i++) begin
            checks++;
            if ({o_dout, o_dout_n, o_sof, o_bit_vld} !== {pat[7-i], ~pat[7-i], i == 0, 1'b1}) begin
                errors++;
                $display("FAIL a5_bit%0d got %b exp %b", i, {o_dout, o_dout_n, o_sof, o_bit_vld}, {pat[7-i], ~pat[7-i], i == 0, 1'b1});
            end
            checks++;
            if (l_dout !== pat[i]) begin errors++; $display("FAIL a5_lsb_bit%0d got %b exp %b", i, l_dout, pat[i]); end
            tick(1'b0, '0, 1'b1);
        end
`ifdef PISO_PARITY_EN
        tick(1'b0, '0, 1'b1);
`endif
        checks++;
        if ({o_dout, o_dout_n, o_bit_vld} !== 3'b010) begin
            errors++;
            $display("FAIL a5_idle got %b exp 010", {o_dout, o_dout_n, o_bit_vld});
        end
    endtask

    task automatic test_back_to_back;
        int run;
        run = 0;
        tick(1'b1, 8'hFF, 1'b1);
        for (int n = 1; n <= 2 * FL + 2; n++) begin
            i_valid = (n <= FL);
            i_data  = 8'h00;
            #1;
            if (o_bit_vld) run++;
            checks++;
            if (o_sof !== (n == 1 || n == FL + 1)) begin
                errors++;
                $display("FAIL b2b_sof n=%0d got %b exp %b", n, o_sof, n == 1 || n == FL + 1);
            end
            checks++;
            if (o_ready !== (n == FL || n >= 2 * FL)) begin
                errors++;
                $display("FAIL b2b_ready n=%0d got %b exp %b", n, o_ready, n == FL || n >= 2 * FL);
            end
            checks++;
            if (o_dout !== (n <= W)) begin errors++; $display("FAIL b2b_dout n=%0d got %b exp %b", n, o_dout, n <= W); end
            @(posedge clk);
            #1;
        end
        checks++;
        if (run != 2 * FL) begin errors++; $display("FAIL b2b_run got %0d exp %0d", run, 2 * FL); end
        idle(1);
    endtask

    task automatic test_lsb_first;
        tick(1'b1, 8'h01, 1'b1);
        for (int i = 0; i < W; i++) begin
            checks++;
            if ({l_dout, o_dout} !== {i == 0, i == W - 1}) begin
                errors++;
                $display("FAIL lsb01_bit%0d got %b exp %b", i, {l_dout, o_dout}, {i == 0, i == W - 1});
            end
            tick(1'b0, '0, 1'b1);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] pat;
        tick(1'b1, 8'h3C, 1'b1);
        idle(3);
        checks++;
        if ({o_dout, o_bit_vld} !== 2'b11) begin errors++; $display("FAIL mid_bit4 got %b exp 11", {o_dout, o_bit_vld}); end
        tick(1'b0, '0, 1'b0);
        i_rst_n = 1'b1;
        #1;
        checks++;
        if ({o_dout, o_bit_vld, o_sof, o_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL mid_after_reset got %b exp 0001", {o_dout, o_bit_vld, o_sof, o_ready});
        end
        pat = 8'h81;
        tick(1'b1, pat, 1'b1);
        for (int i = 0; i < W; i++) begin
            checks++;
            if ({o_dout, o_sof} !== {pat[7-i], i == 0}) begin
                errors++;
                $display("FAIL mid_81_bit%0d got %b exp %b", i, {o_dout, o_sof}, {pat[7-i], i == 0});
            end
            tick(1'b0, '0, 1'b1);
        end
        idle(2);
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity;
        logic [7:0] words [2];
        words[0] = 8'h07;
        words[1] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, words[k], 1'b1);
            idle(W - 1);
            tick(1'b0, '0, 1'b1);
            checks++;
            if ({o_bit_vld, o_dout} !== {1'b1, k == 0}) begin
                errors++;
                $display("FAIL parity_%0d got %b exp %b", k, {o_bit_vld, o_dout}, {1'b1, k == 0});
            end
            idle(2);
        end
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 600; i++)
            tick($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 59) != 0);
        idle(FL + 2);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_frame();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
